// File: rtl/unpacker_if.sv
// Bundles the packed-word input stream and the unpacked pixel output of the
// BGR unpacker so both sides connect through a single port.
interface unpacker_if;
    logic [31:0] in_stream_tdata;
    logic [3:0]  in_stream_tkeep;
    logic        in_stream_tlast;
    logic        in_stream_tuser;
    logic        in_stream_tvalid;
    logic        in_stream_tready;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        valid;
    logic        out_ready;
    logic        sof;
    logic        eol;
    logic        err;

    // Environment side: supplies packed words and pixel back-pressure.
    modport master (
        output in_stream_tdata, in_stream_tkeep, in_stream_tlast,
               in_stream_tuser, in_stream_tvalid, out_ready,
        input  in_stream_tready, r, g, b, valid, sof, eol, err
    );

    // Unpacker side: consumes packed words, produces pixels.
    modport slave (
        input  in_stream_tdata, in_stream_tkeep, in_stream_tlast,
               in_stream_tuser, in_stream_tvalid, out_ready,
        output in_stream_tready, r, g, b, valid, sof, eol, err
    );
endinterface

// File: rtl/unpacker.sv
// BGR byte-stream unpacker: three 32-bit words carry four 24-bit pixels.
// Phases 0-2 pass the incoming word straight through to a pixel with zero
// latency (valid follows tvalid, tready follows out_ready); phase 3 emits
// the fourth pixel purely from the stored residue bytes while the input is
// held off. Framing problems (resync on tuser, early tlast, bad tkeep) set
// a sticky err flag that only areset clears.
module unpacker #(
    parameter bit CHECK_KEEP = 1'b1
) (
    input  logic      aclk,
    input  logic      areset,
    unpacker_if.slave bus
);

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;

    // Position within the 4-pixel group plus the leftover bytes of the
    // previous word that belong to the next pixel(s).
    phase_t     phase_r;
    logic [7:0] res0_r;
    logic [7:0] res1_r;
    logic [7:0] res2_r;
    logic       eol_pending_r;
    logic       err_r;

    phase_t      dec_phase_s;
    logic        resync_s;
    logic        accept_s;
    logic        keep_bad_s;
    logic        err_set_s;
    logic [23:0] pixel_s;
    logic        tready_s;
    logic        valid_s;
    logic        sof_s;
    logic        eol_s;

    // Assemble {r,g,b} for the given phase from the current word and residue.
    function automatic logic [23:0] decode_pixel(
        input phase_t      ph,
        input logic [31:0] d,
        input logic [7:0]  r0,
        input logic [7:0]  r1,
        input logic [7:0]  r2
    );
        logic [23:0] pix;
        case (ph)
            PH0:     pix = {d[23:16], d[15:8], d[7:0]};
            PH1:     pix = {d[15:8], d[7:0], r0};
            PH2:     pix = {d[7:0], r1, r0};
            PH3:     pix = {r2, r1, r0};
            default: pix = {r2, r1, r0};
        endcase
        return pix;
    endfunction

    // Decode the visible pixel and derive handshakes and error causes.
    always_comb begin
        resync_s    = 1'b0;
        dec_phase_s = phase_r;
        // A start-of-frame mid-group restarts the group on this very word.
        if (bus.in_stream_tvalid && bus.in_stream_tuser &&
            (phase_r == PH1 || phase_r == PH2)) begin
            resync_s    = 1'b1;
            dec_phase_s = PH0;
        end else begin
            resync_s    = 1'b0;
            dec_phase_s = phase_r;
        end

        pixel_s = decode_pixel(dec_phase_s, bus.in_stream_tdata, res0_r, res1_r, res2_r);

        if (areset) begin
            tready_s = 1'b0;
            valid_s  = 1'b0;
            sof_s    = 1'b0;
            eol_s    = 1'b0;
        end else if (phase_r == PH3) begin
            // Fourth pixel comes only from residue; input (incl. tuser) waits.
            tready_s = 1'b0;
            valid_s  = 1'b1;
            sof_s    = 1'b0;
            eol_s    = eol_pending_r;
        end else begin
            tready_s = bus.out_ready;
            valid_s  = bus.in_stream_tvalid;
            sof_s    = bus.in_stream_tvalid & bus.in_stream_tuser & (dec_phase_s == PH0);
            // tlast on a phase-2 word is reported on the following phase-3 pixel.
            eol_s    = bus.in_stream_tvalid & bus.in_stream_tlast & (dec_phase_s != PH2);
        end

        accept_s   = tready_s & bus.in_stream_tvalid;
        keep_bad_s = CHECK_KEEP & (bus.in_stream_tkeep != 4'hf);
        // A line ending anywhere but on a group boundary is a framing error.
        err_set_s  = accept_s & (keep_bad_s | resync_s |
                                 (bus.in_stream_tlast & (dec_phase_s != PH2)));
    end

    assign bus.in_stream_tready = tready_s;
    assign bus.valid            = valid_s;
    assign bus.sof              = sof_s;
    assign bus.eol              = eol_s;
    assign bus.r                = areset ? 8'h00 : pixel_s[23:16];
    assign bus.g                = areset ? 8'h00 : pixel_s[15:8];
    assign bus.b                = areset ? 8'h00 : pixel_s[7:0];
    assign bus.err              = err_r & ~areset;

    // Phase/residue FSM: advances on word acceptance in phases 0-2 and on the
    // pixel handshake in phase 3; err accumulates until reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            phase_r       <= PH0;
            res0_r        <= 8'h00;
            res1_r        <= 8'h00;
            res2_r        <= 8'h00;
            eol_pending_r <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            err_r <= err_r | err_set_s;
            case (phase_r)
                PH3: begin
                    if (bus.out_ready) begin
                        phase_r       <= PH0;
                        eol_pending_r <= 1'b0;
                    end
                end
                default: begin
                    if (accept_s) begin
                        case (dec_phase_s)
                            PH0: begin
                                if (bus.in_stream_tlast) begin
                                    phase_r <= PH0;
                                    res0_r  <= 8'h00;
                                end else begin
                                    phase_r <= PH1;
                                    res0_r  <= bus.in_stream_tdata[31:24];
                                end
                                res1_r <= 8'h00;
                                res2_r <= 8'h00;
                            end
                            PH1: begin
                                if (bus.in_stream_tlast) begin
                                    phase_r <= PH0;
                                    res0_r  <= 8'h00;
                                    res1_r  <= 8'h00;
                                end else begin
                                    phase_r <= PH2;
                                    res0_r  <= bus.in_stream_tdata[23:16];
                                    res1_r  <= bus.in_stream_tdata[31:24];
                                end
                            end
                            PH2: begin
                                phase_r       <= PH3;
                                res0_r        <= bus.in_stream_tdata[15:8];
                                res1_r        <= bus.in_stream_tdata[23:16];
                                res2_r        <= bus.in_stream_tdata[31:24];
                                eol_pending_r <= bus.in_stream_tlast;
                            end
                            default: begin
                                phase_r <= PH0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unpacker.sv
// Bench for the BGR unpacker. The reference is a byte-queue model: words are
// appended byte by byte, every three queued bytes form one pixel (B,G,R),
// a line must end on a pixel-group boundary and a frame must start on one.
module tb_unpacker;

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
        logic       sof;
        logic       eol;
    } pix_t;

    logic aclk;
    logic areset;
    logic ready_level;
    logic toggle_en;
    logic started;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] buf_q[$];
    logic [7:0] nbuf_q[$];
    pix_t       exp_q[$];
    pix_t       tmp_q[$];
    pix_t       seen_q[$];
    logic       m_err;
    logic       n_err;

    unpacker_if bus();

    unpacker #(.CHECK_KEEP(1'b1)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Pixel back-pressure: fixed level or toggling every cycle.
    always @(posedge aclk) begin
        #1;
        if (toggle_en) bus.out_ready = ~bus.out_ready;
        else           bus.out_ready = ready_level;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // What accepting word d would produce: pixels in tmp_q, leftovers in nbuf_q.
    task automatic model_word(input logic [31:0] d, input logic u, input logic l,
                              input logic [3:0] k);
        pix_t p;
        bit   first = 1'b1;
        nbuf_q = buf_q;
        n_err  = m_err;
        tmp_q.delete();
        if (k != 4'hf) n_err = 1'b1;
        if (u && nbuf_q.size() != 0) begin
            n_err = 1'b1;
            nbuf_q.delete();
        end
        for (int i = 0; i < 4; i++) nbuf_q.push_back(d[8*i +: 8]);
        while (nbuf_q.size() >= 3) begin
            p.b   = nbuf_q.pop_front();
            p.g   = nbuf_q.pop_front();
            p.r   = nbuf_q.pop_front();
            p.sof = first & u;
            p.eol = 1'b0;
            first = 1'b0;
            tmp_q.push_back(p);
        end
        if (l) begin
            p = tmp_q.pop_back();
            p.eol = 1'b1;
            tmp_q.push_back(p);
            if (nbuf_q.size() != 0) begin
                n_err = 1'b1;
                nbuf_q.delete();
            end
        end
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge aclk) begin
        pix_t act;
        if (started) begin
            act = {bus.b, bus.g, bus.r, bus.sof, bus.eol};
            if (areset) begin
                chk("rst_tready", 32'(bus.in_stream_tready), 32'd0);
                chk("rst_valid", 32'(bus.valid), 32'd0);
                chk("rst_sof_eol_err", 32'({bus.sof, bus.eol, bus.err}), 32'd0);
                chk("rst_rgb", 32'({bus.r, bus.g, bus.b}), 32'd0);
                buf_q.delete();
                exp_q.delete();
                m_err = 1'b0;
            end else begin
                chk("err", 32'(bus.err), 32'(m_err));
                if (exp_q.size() != 0) begin
                    chk("p3_valid", 32'(bus.valid), 32'd1);
                    chk("p3_tready", 32'(bus.in_stream_tready), 32'd0);
                    chk("p3_pixel", 32'(act), 32'(exp_q[0]));
                    if (bus.out_ready) begin
                        seen_q.push_back(act);
                        void'(exp_q.pop_front());
                    end
                end else begin
                    chk("tready", 32'(bus.in_stream_tready), 32'(bus.out_ready));
                    chk("valid", 32'(bus.valid), 32'(bus.in_stream_tvalid));
                    if (bus.in_stream_tvalid) begin
                        model_word(bus.in_stream_tdata, bus.in_stream_tuser,
                                   bus.in_stream_tlast, bus.in_stream_tkeep);
                        chk("pixel", 32'(act), 32'(tmp_q[0]));
                        if (bus.out_ready) begin
                            seen_q.push_back(act);
                            buf_q = nbuf_q;
                            m_err = n_err;
                            for (int i = 1; i < tmp_q.size(); i++) exp_q.push_back(tmp_q[i]);
                        end
                    end
                end
            end
        end
    end

    task automatic idle();
        bus.in_stream_tvalid = 1'b0;
        bus.in_stream_tdata  = 32'h0;
        bus.in_stream_tkeep  = 4'hf;
        bus.in_stream_tlast  = 1'b0;
        bus.in_stream_tuser  = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic u, input logic l, input logic [3:0] k);
        bit acc = 1'b0;
        bus.in_stream_tdata  = d;
        bus.in_stream_tuser  = u;
        bus.in_stream_tlast  = l;
        bus.in_stream_tkeep  = k;
        bus.in_stream_tvalid = 1'b1;
        for (int c = 0; c < 40 && !acc; c++) begin
            @(negedge aclk);
            acc = bus.in_stream_tready;
            @(posedge aclk);
            #1;
        end
        chk("send_accepted", 32'(acc), 32'd1);
        idle();
    endtask

    task automatic drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 40) begin
            @(posedge aclk);
            #1;
            c++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (2) begin
            @(posedge aclk);
            #1;
        end
        areset = 1'b0;
        seen_q.delete();
    endtask

    task automatic want(input int idx, input logic [7:0] b, input logic [7:0] g,
                        input logic [7:0] r, input logic s, input logic e);
        pix_t p;
        p = {b, g, r, s, e};
        if (idx < seen_q.size()) chk($sformatf("lit_pix%0d", idx), 32'(seen_q[idx]), 32'(p));
    endtask

    task automatic std_stream();
        send(32'h44332211, 1'b1, 1'b0, 4'hf);
        send(32'h88776655, 1'b0, 1'b0, 4'hf);
        send(32'hCCBBAA99, 1'b0, 1'b1, 4'hf);
        drain();
    endtask

    task automatic want_std();
        chk("lit_count", 32'(seen_q.size()), 32'd4);
        want(0, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0);
        want(1, 8'h44, 8'h55, 8'h66, 1'b0, 1'b0);
        want(2, 8'h77, 8'h88, 8'h99, 1'b0, 1'b0);
        want(3, 8'hAA, 8'hBB, 8'hCC, 1'b0, 1'b1);
    endtask

    initial begin
        started     = 1'b0;
        toggle_en   = 1'b0;
        ready_level = 1'b1;
        areset      = 1'b1;
        m_err       = 1'b0;
        bus.in_stream_tdata  = 32'hDEADBEEF;
        bus.in_stream_tkeep  = 4'hf;
        bus.in_stream_tlast  = 1'b1;
        bus.in_stream_tuser  = 1'b1;
        bus.in_stream_tvalid = 1'b1;
        #1 started = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        idle();
        areset = 1'b0;
        @(posedge aclk);
        #1;
        chk("lit_err_after_reset", 32'(bus.err), 32'd0);

        // Straight group of four pixels, no back-pressure.
        seen_q.delete();
        std_stream();
        want_std();
        chk("lit_err_clean", 32'(bus.err), 32'd0);

        // Same group with out_ready toggling every cycle.
        seen_q.delete();
        toggle_en = 1'b1;
        std_stream();
        toggle_en = 1'b0;
        repeat (2) begin
            @(posedge aclk);
            #1;
        end
        want_std();
        chk("lit_err_toggle", 32'(bus.err), 32'd0);

        // Start of frame in phase 1 restarts the group.
        do_reset();
        send(32'h44332211, 1'b1, 1'b0, 4'hf);
        send(32'h00FF0000, 1'b1, 1'b0, 4'hf);
        send(32'hDDCCBBAA, 1'b0, 1'b0, 4'hf);
        drain();
        chk("lit_count_resync1", 32'(seen_q.size()), 32'd3);
        want(0, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0);
        want(1, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0);
        want(2, 8'h00, 8'hAA, 8'hBB, 1'b0, 1'b0);
        chk("lit_err_resync1", 32'(bus.err), 32'd1);

        // Line ends on the second word of a group.
        do_reset();
        send(32'h44332211, 1'b1, 1'b0, 4'hf);
        send(32'h88776655, 1'b0, 1'b1, 4'hf);
        send(32'h0C0B0A09, 1'b0, 1'b0, 4'hf);
        drain();
        chk("lit_count_early_last", 32'(seen_q.size()), 32'd3);
        want(0, 8'h11, 8'h22, 8'h33, 1'b1, 1'b0);
        want(1, 8'h44, 8'h55, 8'h66, 1'b0, 1'b1);
        want(2, 8'h09, 8'h0A, 8'h0B, 1'b0, 1'b0);
        chk("lit_err_early_last", 32'(bus.err), 32'd1);

        // Reset in the middle of a group drops the partial pixels.
        do_reset();
        send(32'h44332211, 1'b1, 1'b0, 4'hf);
        send(32'h88776655, 1'b0, 1'b0, 4'hf);
        do_reset();
        send(32'h00030201, 1'b0, 1'b0, 4'hf);
        drain();
        chk("lit_count_midreset", 32'(seen_q.size()), 32'd1);
        want(0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
        chk("lit_err_midreset", 32'(bus.err), 32'd0);

        // Partial byte enables flag an error but data is still decoded.
        do_reset();
        send(32'h44332211, 1'b1, 1'b0, 4'h7);
        chk("lit_err_keep", 32'(bus.err), 32'd1);
        send(32'h88776655, 1'b0, 1'b0, 4'hf);
        send(32'hCCBBAA99, 1'b0, 1'b1, 4'hf);
        drain();
        want_std();

        // Start of frame in phase 2 restarts the group.
        do_reset();
        send(32'h44332211, 1'b1, 1'b0, 4'hf);
        send(32'h88776655, 1'b0, 1'b0, 4'hf);
        send(32'h0F0E0D0C, 1'b1, 1'b0, 4'hf);
        drain();
        chk("lit_count_resync2", 32'(seen_q.size()), 32'd3);
        want(2, 8'h0C, 8'h0D, 8'h0E, 1'b1, 1'b0);
        chk("lit_err_resync2", 32'(bus.err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unpacker.md
UNPACKER -- requirements
Module: unpacker

Interface
REQ-001 CHECK_KEEP, 1, when 1 a beat with in_stream_tkeep != 4'hf sets err.
REQ-002 aclk  in  1  single clock; all state updates on rising edge.
REQ-003 areset  in  1  synchronous, active-high reset.
REQ-004 in_stream_tdata  in  32  packed byte stream, byte0 = bits[7:0] first in stream order.
REQ-005 in_stream_tkeep  in  4  byte enables; all-ones required.
REQ-006 in_stream_tlast  in  1  last word of a line.
REQ-007 in_stream_tuser  in  1  start of frame; set on the first word of a frame.
REQ-008 in_stream_tvalid  in  1  input word valid.
REQ-009 in_stream_tready  out  1  input word accepted when tvalid & tready.
REQ-010 r, g, b  out  8 each  unpacked pixel colour.
REQ-011 valid  out  1  pixel valid.
REQ-012 out_ready  in  1  downstream accepts pixel when valid & out_ready.
REQ-013 sof  out  1  pixel is first of frame.
REQ-014 eol  out  1  pixel is last of line.
REQ-015 err  out  1  sticky framing error flag.

Function
REQ-016 The stream byte order SHALL be B,G,R per pixel; 3 words carry 4 pixels (12 bytes).
REQ-017 A 2-bit phase register (0..3) and a 24-bit residue register (res0..res2) SHALL track position within a 4-pixel group.
REQ-018 Phase 0: pixel = {b=d[7:0], g=d[15:8], r=d[23:16]}; res0 <= d[31:24]; next phase 1.
REQ-019 Phase 1: pixel = {b=res0, g=d[7:0], r=d[15:8]}; res0,res1 <= d[23:16],d[31:24]; next phase 2.
REQ-020 Phase 2: pixel = {b=res0, g=res1, r=d[7:0]}; res0..res2 <= d[15:8],d[23:16],d[31:24]; next phase 3.
REQ-021 Phase 3: pixel = {b=res0, g=res1, r=res2}; no word consumed; in_stream_tready=0; valid=1; next phase 0 on out_ready.
REQ-022 Phases 0-2: valid = in_stream_tvalid, in_stream_tready = out_ready (zero-latency combinational pass), state advances only when both handshakes fire.
REQ-023 r/g/b/sof/eol SHALL be held stable while valid & !out_ready.
REQ-024 sof SHALL be 1 on the phase-0 pixel of a word with tuser=1, 0 otherwise.
REQ-025 tuser=1 with tvalid in phase 1 or 2 SHALL resync: word treated as phase 0 (new frame), residue discarded, err set.
REQ-026 tlast accepted in phase 2 SHALL set eol_pending; phase-3 pixel SHALL carry eol=1, clearing eol_pending on its handshake.
REQ-027 tlast accepted in phase 0 or 1 SHALL output that pixel with eol=1, set err, discard residue, next phase 0.
REQ-028 err SHALL be sticky, cleared only by areset; CHECK_KEEP violation sets err but data is still processed as all bytes valid.
REQ-029 Phase-3 pixel with pending sof-resync SHALL not occur; tuser seen in phase 3 is held off (tready=0) until phase 0.

Reset
REQ-030 While areset=1: in_stream_tready=0, valid=0, sof=0, eol=0, err=0.
REQ-031 On areset: phase=0, residue=0, eol_pending=0; reset mid-group discards partial pixels.

Verification
REQ-032 Words 0x44332211(tuser), 0x88776655, 0xCCBBAA99(tlast), out_ready=1 -> pixels (b,g,r) 11/22/33 sof=1, 44/55/66, 77/88/99, AA/BB/CC eol=1; err=0.
REQ-033 Same stream, out_ready toggling 1/0 each cycle -> identical 4 pixels, each held stable while stalled, tready=0 during phase 3.
REQ-034 tuser word 0x00FF0000 in phase 1 -> pixel b=00,g=00,r=FF sof=1, err=1, next word decoded as phase 1.
REQ-035 tlast on 2nd word (phase 1) -> that pixel eol=1, err=1, next word decoded as phase 0.
REQ-036 areset pulsed after 2nd word -> outputs zero during reset; next word 0x00030201 -> b=01,g=02,r=03, err=0.
REQ-037 CHECK_KEEP=1, tkeep=4'h7 on a word -> err=1, pixels still decoded per REQ-018..021.
